// File: rtl/pio_in_capture.sv
// Avalon-MM GPIO input: pin sync, optional per-bit debounce, edge capture (W1C), masked level IRQ.
// Read latency 1 cycle; slave never stalls the bus (no waitrequest); pin-to-capture SYNC_STAGES+1 (+DEBOUNCE_CYCLES).
module pio_in_capture #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;
    localparam logic [2:0] ARM_DONE  = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [2:0]       arm_cnt_q, arm_cnt_d;
    logic             armed;
    logic             wr_en;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_db
            assign stable = sync_val;
        end else begin : g_db
            localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                logic [15:0] cnt_q, cnt_d;
                logic        bit_q, bit_d;

                // Counter only runs while the synchronised pin disagrees with the accepted value.
                always_comb begin
                    cnt_d = '0;
                    bit_d = bit_q;
                    if (sync_val[i] != bit_q) begin
                        if (cnt_q == DB_LAST) begin
                            bit_d = sync_val[i];
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                end

                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt_q <= '0;
                        bit_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                        bit_q <= bit_d;
                    end
                end

                assign stable[i] = bit_q;
            end
        end
    endgenerate

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_sel = stable & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_sel = ~stable & prev_q;
        end else begin
            edge_sel = (stable & ~prev_q) | (~stable & prev_q);
        end
    end

    // Pins already high at reset would look like rising edges while the chain fills.
    assign armed    = (arm_cnt_q == ARM_DONE);
    assign edge_evt = armed ? edge_sel : '0;
    assign wr_en    = chipselect && !write_n;

    always_comb begin
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 3'd1;
        irqmask_d  = irqmask_q;
        edgecap_d  = edgecap_q;
        readdata_d = '0;
        irq_d      = |(edgecap_q & irqmask_q);
        if (wr_en && address == ADDR_MASK) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGE) begin
            edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
        end
        edgecap_d = edgecap_d | edge_evt;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
            ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edgecap_q;
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            arm_cnt_q  <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= stable;
            arm_cnt_q  <= arm_cnt_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_capture.sv
// Four differently parameterised instances share one bus and pin set; a history-based model predicts every cycle.
// Expected readdata/irq are queued at each clock edge and popped by the negedge monitor.
module tb_pio_in_capture;
    localparam int NI = 4;

    typedef struct packed {
        logic [NI-1:0]       irq;
        logic [NI-1:0][31:0] rd;
    } exp_t;

    int ps [NI] = '{2, 3, 2, 4};
    int pd [NI] = '{0, 0, 16, 3};
    int pe [NI] = '{0, 2, 2, 1};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rdo [NI];
    logic        irqo [NI];

    exp_t expq [$];
    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] m_st [NI];
    logic [7:0] m_prv [NI];
    logic [7:0] m_ec [NI];
    logic [7:0] m_mask [NI];
    logic [7:0] h_in [128];
    logic [7:0] h_sync [NI][128];
    int         m_n;

    always #5 clk = ~clk;

    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdo[0]), .in_port(in_port), .irq(irqo[0]));
    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdo[1]), .in_port(in_port), .irq(irqo[1]));
    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .EDGE_TYPE(2)) u_c (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdo[2]), .in_port(in_port), .irq(irqo[2]));
    pio_in_capture #(.WIDTH(8), .SYNC_STAGES(4), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(1)) u_d (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rdo[3]), .in_port(in_port), .irq(irqo[3]));

    task automatic check(input string nm, input int j, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s[u%0d] at %0t: got 0x%08h, required 0x%08h", nm, j, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int j = 0; j < NI; j++) begin
            m_st[j] = 8'h00; m_prv[j] = 8'h00; m_ec[j] = 8'h00; m_mask[j] = 8'h00;
        end
        m_n = 0;
    endtask

    // One clock edge for instance j. The synchronised value is simply the pin S edges ago;
    // a debounced bit flips once the last D synchronised samples all disagree with it.
    task automatic step(input int j, output logic [31:0] rd, output logic irq_e);
        logic [7:0] syn, stb, evt, clr;
        logic       all_diff;
        syn = (m_n >= ps[j]) ? h_in[(m_n - ps[j]) % 128] : 8'h00;
        stb = (pd[j] == 0) ? syn : m_st[j];
        case (pe[j])
            0:       evt = stb & ~m_prv[j];
            1:       evt = ~stb & m_prv[j];
            default: evt = stb ^ m_prv[j];
        endcase
        if (m_n < ps[j] + 1) evt = 8'h00;
        case (address)
            2'd0:    rd = {24'h0, stb};
            2'd2:    rd = {24'h0, m_mask[j]};
            2'd3:    rd = {24'h0, m_ec[j]};
            default: rd = 32'h0;
        endcase
        irq_e = |(m_ec[j] & m_mask[j]);
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
        m_ec[j] = (m_ec[j] & ~clr) | evt;
        if (chipselect && !write_n && address == 2'd2) m_mask[j] = writedata[7:0];
        m_prv[j] = stb;
        if (pd[j] > 0) begin
            h_sync[j][m_n % 128] = syn;
            if (m_n + 1 >= pd[j]) begin
                for (int b = 0; b < 8; b++) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < pd[j]; k++)
                        if (h_sync[j][(m_n - k) % 128][b] == m_st[j][b]) all_diff = 1'b0;
                    if (all_diff) m_st[j][b] = ~m_st[j][b];
                end
            end
        end
    endtask

    always @(negedge reset_n) begin
        model_clear();
        expq.delete();
    end

    always @(posedge clk) begin
        exp_t        e;
        logic [31:0] r;
        logic        q;
        e = '0;
        if (reset_n) begin
            for (int j = 0; j < NI; j++) begin
                step(j, r, q);
                e.rd[j]  = r;
                e.irq[j] = q;
            end
            h_in[m_n % 128] = in_port;
            m_n++;
        end
        expq.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            for (int j = 0; j < NI; j++) begin
                check("readdata", j, rdo[j], e.rd[j]);
                check("irq", j, {31'h0, irqo[j]}, {31'h0, e.irq[j]});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_chk(input int j, input logic [1:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        address = a; chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        check(nm, j, rdo[j], exp);
    endtask

    task automatic irq_chk(input int j, input logic exp, input string nm);
        check(nm, j, {31'h0, irqo[j]}, {31'h0, exp});
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 8'hA5;
        model_clear();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // High pins through reset must show on DATA without a capture
        idle(10);
        rd_chk(0, 2'd0, 32'hA5, "rst_data");
        irq_chk(0, 1'b0, "rst_irq");
        rd_chk(0, 2'd2, 32'h0, "rst_mask");
        rd_chk(0, 2'd3, 32'h0, "rst_edge");

        // Rising capture, irq, then W1C
        in_port = 8'h00;
        idle(40);
        wr(2'd3, 32'hFF);
        wr(2'd2, 32'h01);
        in_port = 8'h01;
        idle(5);
        rd_chk(0, 2'd3, 32'h01, "rise_edge");
        irq_chk(0, 1'b1, "rise_irq");
        wr(2'd3, 32'h01);
        idle(2);
        irq_chk(0, 1'b0, "w1c_irq");
        rd_chk(0, 2'd3, 32'h0, "w1c_edge");

        // Any-edge capture while masked, then unmask
        wr(2'd2, 32'h00);
        in_port = 8'h09;
        idle(40);
        wr(2'd3, 32'hFF);
        in_port = 8'h01;
        idle(8);
        rd_chk(1, 2'd3, 32'h08, "fall_edge_any");
        irq_chk(1, 1'b0, "masked_irq");
        wr(2'd2, 32'h08);
        idle(1);
        irq_chk(1, 1'b1, "unmask_irq");

        // Debounce: 10-cycle glitch rejected, long hold accepted
        wr(2'd2, 32'h00);
        in_port = 8'h00;
        idle(40);
        wr(2'd3, 32'hFF);
        in_port = 8'h01;
        idle(10);
        in_port = 8'h00;
        idle(30);
        rd_chk(2, 2'd0, 32'h0, "db_glitch_data");
        rd_chk(2, 2'd3, 32'h0, "db_glitch_edge");
        in_port = 8'h01;
        idle(25);
        rd_chk(2, 2'd0, 32'h01, "db_data");
        rd_chk(2, 2'd3, 32'h01, "db_edge");

        // W1C lands on the same edge as bit2's capture on u_a
        idle(5);
        wr(2'd3, 32'hFF);
        idle(3);
        in_port = 8'h05;
        @(negedge clk);
        wr(2'd3, 32'h04);
        rd_chk(0, 2'd3, 32'h04, "collide_edge");

        // Randomised traffic, alternating fast-toggling and slow-changing pins
        for (int it = 0; it < 1500; it++) begin
            @(negedge clk);
            if ($urandom_range(0, ((it / 300) % 2 == 1) ? 40 : 3) == 0) in_port = 8'($urandom);
            address    = 2'($urandom);
            chipselect = ($urandom_range(0, 3) == 0);
            write_n    = 1'($urandom);
            writedata  = $urandom;
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;

        // Mid-operation asynchronous reset
        wr(2'd2, 32'hFF);
        in_port = 8'h00;
        idle(40);
        wr(2'd3, 32'hFF);
        in_port = 8'hFF;
        idle(30);
        rd_chk(0, 2'd3, 32'hFF, "pre_rst_edge");
        irq_chk(0, 1'b1, "pre_rst_irq");
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        for (int j = 0; j < NI; j++) begin
            check("async_rst_irq", j, {31'h0, irqo[j]}, 32'h0);
            check("async_rst_rd", j, rdo[j], 32'h0);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        idle(20);
        rd_chk(0, 2'd3, 32'h0, "post_rst_edge");
        rd_chk(0, 2'd0, 32'hFF, "post_rst_data");
        rd_chk(0, 2'd2, 32'h0, "post_rst_mask");
        irq_chk(0, 1'b0, "post_rst_irq");
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
